// File: rtl/stream_arb2.sv
// Two-source round-robin stream arbiter with a registered output beat.
// Optional per-source saturating grant counters via STREAM_ARB2_GRANT_CNT_EN.
module stream_arb2 #(
    parameter int DWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in0_valid,
    input  logic [DWIDTH-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DWIDTH-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready
`ifdef STREAM_ARB2_GRANT_CNT_EN
    ,
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1
`endif
);

    // Select encoding shared by out_sel and last_grant: 1 = source 0, 0 = source 1.
    localparam logic SEL_SRC0 = 1'b1;
    localparam logic SEL_SRC1 = 1'b0;

    logic              out_valid_r;
    logic [DWIDTH-1:0] out_data_r;
    logic              out_sel_r;
    logic              last_grant_r;
    logic              load_en_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              xfer0_s;
    logic              xfer1_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    assign load_en_s = ~out_valid_r | out_ready;

    // Grant decision: a lone requester wins, contention goes to the source not granted last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (in0_valid && in1_valid) begin
            grant0_s = (last_grant_r == SEL_SRC1);
            grant1_s = (last_grant_r == SEL_SRC0);
        end else if (in0_valid) begin
            grant0_s = 1'b1;
        end else if (in1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Ready is gated by reset_n so neither source sees acceptance while reset is held.
    assign xfer0_s   = reset_n & load_en_s & grant0_s;
    assign xfer1_s   = reset_n & load_en_s & grant1_s;
    assign in0_ready = xfer0_s;
    assign in1_ready = xfer1_s;

    // Output beat register and round-robin history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DWIDTH{1'b0}};
            out_sel_r    <= SEL_SRC1;
            last_grant_r <= SEL_SRC1;
        end else if (load_en_s) begin
            if (xfer0_s) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= in0_data;
                out_sel_r    <= SEL_SRC0;
                last_grant_r <= SEL_SRC0;
            end else if (xfer1_s) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= in1_data;
                out_sel_r    <= SEL_SRC1;
                last_grant_r <= SEL_SRC1;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

`ifdef STREAM_ARB2_GRANT_CNT_EN
    logic [7:0] grant_cnt0_r;
    logic [7:0] grant_cnt1_r;

    // Per-source transfer counters, saturating at 255.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0_r <= 8'd0;
            grant_cnt1_r <= 8'd0;
        end else if (xfer0_s) begin
            grant_cnt0_r <= sat_inc(grant_cnt0_r);
        end else if (xfer1_s) begin
            grant_cnt1_r <= sat_inc(grant_cnt1_r);
        end else begin
            grant_cnt0_r <= grant_cnt0_r;
        end
    end

    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 6, giving the data width of every data port.
REQ-002 The module SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have ports in0_valid (input, 1) and in0_data (input, DWIDTH), source 0 request and payload.
REQ-005 The module SHALL have port in0_ready, output, 1, asserted when source 0's beat is accepted this cycle.
REQ-006 The module SHALL have ports in1_valid (input, 1), in1_data (input, DWIDTH) and in1_ready (output, 1), the source 1 equivalents.
REQ-007 The module SHALL have ports out_valid (output, 1) and out_data (output, DWIDTH), the registered output beat.
REQ-008 The module SHALL have port out_ready, input, 1, downstream acceptance.
REQ-009 The module SHALL have port out_sel, output, 1: 1 = current out_data came from source 0, 0 = from source 1; this matches the select polarity of the downstream 2:1 data mux.

Function
REQ-010 A beat SHALL transfer on any port only in a cycle where its valid and ready are both 1.
REQ-011 The output register SHALL be loadable when out_valid==0 or out_ready==1 (load_en).
REQ-012 in0_ready and in1_ready SHALL be combinational: at most one is 1, and only when load_en==1 and that source holds the grant.
REQ-013 Grant rule: one source valid -> grant it; both valid -> grant the source other than last_grant; neither valid -> no grant.
REQ-014 last_grant SHALL update to the granted source only on a transfer; it SHALL NOT change in stall or idle cycles.
REQ-015 On a transfer, out_data, out_sel and out_valid SHALL be loaded on the next rising edge; input-to-output latency is exactly 1 cycle.
REQ-016 When load_en==1 and no source is granted, out_valid SHALL go to 0 on the next edge.
REQ-017 While out_valid==1 and out_ready==0, out_data, out_sel and out_valid SHALL hold, and both in*_ready SHALL be 0.
REQ-018 Sustained throughput SHALL be 1 beat per cycle with out_ready held at 1.
REQ-019 With both sources continuously valid, grants SHALL strictly alternate, so neither source waits more than one transfer.
REQ-020 A source's valid dropping before acceptance SHALL be tolerated; the grant is re-evaluated each cycle.
REQ-021 in*_ready SHALL NOT depend combinationally on in*_data.

Reset
REQ-022 While reset_n==0: out_valid=0, out_data=0, out_sel=0, last_grant=source 1 (so source 0 wins the first contention), in0_ready=0, in1_ready=0.
REQ-023 Reset asserted mid-transfer SHALL discard any held beat immediately (asynchronously); no beat is replayed after release.
REQ-024 On the first edge after reset_n rises, the block SHALL behave as in REQ-013 with no dead cycle.

Configuration
REQ-025 Macro STREAM_ARB2_GRANT_CNT_EN SHALL, when defined, add outputs grant_cnt0 and grant_cnt1 (8 bits each): per-source transfer counts that saturate at 255, reset to 0 and update on each transfer.
REQ-026 Without STREAM_ARB2_GRANT_CNT_EN, the counters and ports SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Reset release, in0_valid=1 data=0x15, in1 idle, out_ready=1 -> in0_ready=1 that cycle; next cycle out_valid=1, out_data=0x15, out_sel=1.
REQ-028 Both valid every cycle (in0=0x0A, in1=0x35), out_ready=1 -> out_sel sequence 1,0,1,0..., out_data 0x0A,0x35,... one beat per cycle.
REQ-029 Output holding 0x0A, out_ready=0 for 3 cycles with both sources valid -> out_data/out_sel stable, both ready=0; then out_ready=1 -> source 1 (0x35) granted next.
REQ-030 Only in1 valid, data 0x3F, out_ready=1 for 4 cycles -> 4 beats of 0x3F, out_sel=0, last_grant=source 1; then both valid -> source 0 granted.
REQ-031 reset_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release with no valid input -> out_valid stays 0.
REQ-032 With STREAM_ARB2_GRANT_CNT_EN, 300 source-0 transfers -> grant_cnt0=255 (saturated), grant_cnt1=0.
